apb_req_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares the single APB master transfer port (`transfer`, `read_write`, `apb_write_paddr`, `apb_write_data`, `apb_read_paddr`, `apb_read_data_out`) between NREQ requesters. It serializes requests, holds each one on the master port until completion or timeout, and returns read data and status to the owning requester. It sits between the requester logic and the APB master/slave top.

---
 rtl/apb_req_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_apb_req_arbiter.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter/sequencer sharing one APB master transfer port among NREQ requesters.
// Latency: grant is combinational in IDLE, m_transfer from the next cycle, rsp_valid one cycle after m_done or timeout.
// Backpressure: one transaction in flight; req_ready stays low outside IDLE, so requesters hold req_valid until granted.
module apb_req_arbiter #(
    parameter int NREQ    = 4,
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic                     pclk,
    input  logic                     preset,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ-1:0]          req_write,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_wdata,
    output logic [NREQ-1:0]          req_ready,
    output logic [NREQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]        rsp_rdata,
    output logic                     rsp_err,
    output logic                     m_transfer,
    output logic                     m_read_write,
    output logic [ADDR_W-1:0]        m_write_paddr,
    output logic [DATA_W-1:0]        m_write_data,
    output logic [ADDR_W-1:0]        m_read_paddr,
    input  logic [DATA_W-1:0]        m_read_data,
    input  logic                     m_done
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [PW-1:0] LAST_REQ = PW'(NREQ - 1);
    localparam logic [TW-1:0] TCNT_MAX = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic [PW-1:0]     ptr;        // first requester examined by the next search
    logic [PW-1:0]     win;        // round-robin winner this cycle
    logic              any_req;
    logic [PW-1:0]     owner;      // requester whose transaction is in flight
    logic [TW-1:0]     tcnt;       // 0-based count of BUSY cycles without m_done

    logic              accept;
    logic              busy_done;
    logic              busy_tmo;

    logic [ADDR_W-1:0] addr_arr  [NREQ];
    logic [DATA_W-1:0] wdata_arr [NREQ];

    // Wrap base+k into the requester range without a general modulo.
    function automatic logic [PW-1:0] rr_index(input logic [PW-1:0] base, input int k);
        int sum;
        sum = int'(base) + k;
        if (sum >= NREQ) begin
            sum = sum - NREQ;
        end
        return PW'(sum);
    endfunction

    // Unpack the flat requester buses into per-requester fields.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
        assign wdata_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];
    end

    // Round-robin search: first valid requester at or after ptr, wrapping.
    always_comb begin
        win     = '0;
        any_req = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!any_req && req_valid[rr_index(ptr, k)]) begin
                any_req = 1'b1;
                win     = rr_index(ptr, k);
            end
        end
    end

    // Next-state logic and the combinational accept strobe.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        busy_done = 1'b0;
        busy_tmo  = 1'b0;
        req_ready = '0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    accept         = 1'b1;
                    req_ready[win] = 1'b1;
                    state_nxt      = BUSY;
                end
            end
            BUSY: begin
                // Completion takes priority over a timeout in the same cycle.
                if (m_done) begin
                    busy_done = 1'b1;
                    state_nxt = RESP;
                end else if (tcnt == TCNT_MAX) begin
                    busy_tmo  = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge pclk) begin
        if (preset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Round-robin pointer and owner of the in-flight transaction.
    always_ff @(posedge pclk) begin
        if (preset) begin
            ptr   <= '0;
            owner <= '0;
        end else if (accept) begin
            owner <= win;
            ptr   <= (win == LAST_REQ) ? '0 : win + 1'b1;
        end
    end

    // BUSY cycle counter, restarted on every accept.
    always_ff @(posedge pclk) begin
        if (preset) begin
            tcnt <= '0;
        end else if (accept) begin
            tcnt <= '0;
        end else if (state == BUSY && !busy_done && !busy_tmo) begin
            tcnt <= tcnt + 1'b1;
        end
    end

    // Master port: load the winner's fields on accept, hold through BUSY, clear on exit.
    always_ff @(posedge pclk) begin
        if (preset) begin
            m_transfer    <= 1'b0;
            m_read_write  <= 1'b0;
            m_write_paddr <= '0;
            m_write_data  <= '0;
            m_read_paddr  <= '0;
        end else if (accept) begin
            m_transfer    <= 1'b1;
            m_read_write  <= ~req_write[win];
            m_write_paddr <= req_write[win] ? addr_arr[win]  : '0;
            m_write_data  <= req_write[win] ? wdata_arr[win] : '0;
            m_read_paddr  <= req_write[win] ? '0 : addr_arr[win];
        end else if (busy_done || busy_tmo) begin
            m_transfer    <= 1'b0;
            m_read_write  <= 1'b0;
            m_write_paddr <= '0;
            m_write_data  <= '0;
            m_read_paddr  <= '0;
        end
    end

    // Response: one-cycle pulse to the owner; data/err hold until the next completion.
    always_ff @(posedge pclk) begin
        if (preset) begin
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= '0;
            if (busy_done) begin
                rsp_valid        <= '0;
                rsp_valid[owner] <= 1'b1;
                // m_read_write still reflects the in-flight direction here.
                rsp_rdata        <= m_read_write ? m_read_data : '0;
                rsp_err          <= 1'b0;
            end else if (busy_tmo) begin
                rsp_valid        <= '0;
                rsp_valid[owner] <= 1'b1;
                rsp_rdata        <= '0;
                rsp_err          <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Bench for apb_req_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
// Driver predicts grants, transfers and responses into queues; a negedge monitor pops and compares.
// The bench plays the APB side, choosing when m_done fires (including never, to force timeouts).
module tb_apb_req_arbiter;

    localparam int NREQ    = 4;
    localparam int ADDR_W  = 9;
    localparam int DATA_W  = 8;
    localparam int TIMEOUT = 16;
    localparam int PW      = 2;

    logic                   pclk = 1'b0;
    logic                   preset;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_write;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ*DATA_W-1:0] req_wdata;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]      rsp_rdata;
    logic                   rsp_err;
    logic                   m_transfer;
    logic                   m_read_write;
    logic [ADDR_W-1:0]      m_write_paddr;
    logic [DATA_W-1:0]      m_write_data;
    logic [ADDR_W-1:0]      m_read_paddr;
    logic [DATA_W-1:0]      m_read_data;
    logic                   m_done;

    logic [ADDR_W-1:0]      a_arr [NREQ];
    logic [DATA_W-1:0]      d_arr [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_pack
        assign req_addr[gi*ADDR_W +: ADDR_W]  = a_arr[gi];
        assign req_wdata[gi*DATA_W +: DATA_W] = d_arr[gi];
    end

    apb_req_arbiter #(
        .NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .pclk(pclk), .preset(preset),
        .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .m_transfer(m_transfer), .m_read_write(m_read_write),
        .m_write_paddr(m_write_paddr), .m_write_data(m_write_data),
        .m_read_paddr(m_read_paddr), .m_read_data(m_read_data),
        .m_done(m_done)
    );

    always #5 pclk = ~pclk;

    int cyc = 0;
    always @(posedge pclk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct { int cyc; int idx; } grant_t;
    typedef struct { int cyc; int idx; logic [DATA_W-1:0] rdata; logic err; } rsp_t;
    typedef struct {
        int len; logic rw;
        logic [ADDR_W-1:0] wa; logic [DATA_W-1:0] wd; logic [ADDR_W-1:0] ra;
    } xfer_t;

    grant_t gq[$];
    rsp_t   rq[$];
    xfer_t  xq[$];

    // Transaction-level model: phase 0 idle, 1 transfer in progress, 2 response cycle.
    int                mphase = 0;
    int                mptr   = 0;
    int                mw     = 0;
    int                mbc    = 0;
    int                md     = 0;
    logic              mwr;
    logic [ADDR_W-1:0] maddr;
    logic [DATA_W-1:0] mwd;
    logic [DATA_W-1:0] mrd;
    int                next_d = 1;
    logic [DATA_W-1:0] next_rdata;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic vbit(input logic [NREQ-1:0] v, input int i);
        logic [PW-1:0] ix;
        ix = PW'(i);
        return v[ix];
    endfunction

    function automatic logic [NREQ-1:0] onehot(input int i);
        logic [NREQ-1:0] v;
        logic [PW-1:0]   ix;
        v = '0;
        ix = PW'(i);
        v[ix] = 1'b1;
        return v;
    endfunction

    task automatic push_rsp(input logic [DATA_W-1:0] rd, input logic err);
        rsp_t r;
        r.cyc = cyc + 1; r.idx = mw; r.rdata = rd; r.err = err;
        rq.push_back(r);
    endtask

    task automatic push_xfer(input int len);
        xfer_t x;
        x.len = len;
        x.rw  = ~mwr;
        x.wa  = mwr ? maddr : '0;
        x.wd  = mwr ? mwd   : '0;
        x.ra  = mwr ? '0    : maddr;
        xq.push_back(x);
    endtask

    // One clock cycle: model reacts to the inputs currently driven, plays the APB side, advances.
    task automatic step();
        int     nphase;
        grant_t g;
        nphase      = mphase;
        m_done      = 1'b0;
        m_read_data = DATA_W'($urandom);
        if (mphase == 0 && !preset && req_valid != '0) begin
            mw = -1;
            for (int k = 0; k < NREQ; k++) begin
                if (mw < 0 && vbit(req_valid, (mptr + k) % NREQ)) mw = (mptr + k) % NREQ;
            end
            g.cyc = cyc; g.idx = mw;
            gq.push_back(g);
            mwr   = vbit(req_write, mw);
            maddr = a_arr[mw];
            mwd   = d_arr[mw];
            mptr  = (mw + 1) % NREQ;
            mbc   = 0;
            md    = next_d;
            mrd   = next_rdata;
            nphase = 1;
        end else if (mphase == 1) begin
            mbc++;
            if (preset) begin
                push_xfer(mbc);
            end else if (mbc == md) begin
                m_done      = 1'b1;
                m_read_data = mrd;
                push_rsp(mwr ? '0 : mrd, 1'b0);
                push_xfer(mbc);
                nphase = 2;
            end else if (mbc == TIMEOUT) begin
                push_rsp('0, 1'b1);
                push_xfer(TIMEOUT);
                nphase = 2;
            end
        end else begin
            // Stray completions outside a transfer must be ignored.
            if (mphase == 2) nphase = 0;
            m_done = ($urandom_range(0, 3) == 0);
        end
        if (preset) begin
            nphase = 0;
            mptr   = 0;
        end
        @(posedge pclk);
        #1;
        mphase = nphase;
    endtask

    task automatic drain();
        int guard;
        req_valid = '0;
        guard = 0;
        while (mphase != 0 && guard < TIMEOUT + 8) begin
            step();
            guard++;
        end
    endtask

    task automatic set_req(input int i, input logic wr, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d);
        logic [PW-1:0] ix;
        ix = PW'(i);
        a_arr[i]      = a;
        d_arr[i]      = d;
        req_write[ix] = wr;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_req_ready",     32'(req_ready),     32'(0));
        chk("rst_rsp_valid",     32'(rsp_valid),     32'(0));
        chk("rst_rsp_rdata",     32'(rsp_rdata),     32'(0));
        chk("rst_rsp_err",       32'(rsp_err),       32'(0));
        chk("rst_m_transfer",    32'(m_transfer),    32'(0));
        chk("rst_m_read_write",  32'(m_read_write),  32'(0));
        chk("rst_m_write_paddr", 32'(m_write_paddr), 32'(0));
        chk("rst_m_write_data",  32'(m_write_data),  32'(0));
        chk("rst_m_read_paddr",  32'(m_read_paddr),  32'(0));
    endtask

    // Monitor: pops expectations whenever the DUT shows a grant, a transfer ending, or a response.
    logic              mon_on = 1'b0;
    logic              in_x   = 1'b0;
    int                xlen   = 0;
    logic              hold_bad;
    logic              c_rw;
    logic [ADDR_W-1:0] c_wa;
    logic [DATA_W-1:0] c_wd;
    logic [ADDR_W-1:0] c_ra;
    grant_t            mg;
    rsp_t              mr;
    xfer_t             mx;

    always @(negedge pclk) begin
        if (mon_on) begin
            if (req_ready != '0) begin
                if (gq.size() == 0) begin
                    chk("grant_unexpected", 32'(req_ready), 32'(0));
                end else begin
                    mg = gq.pop_front();
                    chk("grant_vector", 32'(req_ready), 32'(onehot(mg.idx)));
                    chk("grant_cycle",  32'(cyc),       32'(mg.cyc));
                end
            end
            if (m_transfer) begin
                if (!in_x) begin
                    in_x = 1'b1; xlen = 0; hold_bad = 1'b0;
                    c_rw = m_read_write; c_wa = m_write_paddr;
                    c_wd = m_write_data; c_ra = m_read_paddr;
                end else if (m_read_write !== c_rw || m_write_paddr !== c_wa ||
                             m_write_data !== c_wd || m_read_paddr !== c_ra) begin
                    hold_bad = 1'b1;
                end
                xlen++;
            end else if (in_x) begin
                in_x = 1'b0;
                if (xq.size() == 0) begin
                    chk("xfer_unexpected", 32'(xlen), 32'(0));
                end else begin
                    mx = xq.pop_front();
                    chk("xfer_len",        32'(xlen),     32'(mx.len));
                    chk("xfer_read_write", 32'(c_rw),     32'(mx.rw));
                    chk("xfer_write_addr", 32'(c_wa),     32'(mx.wa));
                    chk("xfer_write_data", 32'(c_wd),     32'(mx.wd));
                    chk("xfer_read_addr",  32'(c_ra),     32'(mx.ra));
                    chk("xfer_hold",       32'(hold_bad), 32'(0));
                end
            end
            if (rsp_valid != '0) begin
                if (rq.size() == 0) begin
                    chk("rsp_unexpected", 32'(rsp_valid), 32'(0));
                end else begin
                    mr = rq.pop_front();
                    chk("rsp_vector", 32'(rsp_valid), 32'(onehot(mr.idx)));
                    chk("rsp_cycle",  32'(cyc),       32'(mr.cyc));
                    chk("rsp_rdata",  32'(rsp_rdata), 32'(mr.rdata));
                    chk("rsp_err",    32'(rsp_err),   32'(mr.err));
                end
            end
        end
    end

    initial begin
        preset      = 1'b1;
        req_valid   = '0;
        req_write   = '0;
        m_done      = 1'b0;
        m_read_data = '0;
        next_rdata  = '0;
        for (int i = 0; i < NREQ; i++) begin
            a_arr[i] = '0;
            d_arr[i] = '0;
        end
        step();
        step();
        chk_reset_outputs();
        preset = 1'b0;
        mon_on = 1'b1;

        // Single write from requester 0, done on the 3rd transfer cycle.
        set_req(0, 1'b1, 9'h05A, 8'hC3);
        req_valid = 4'b0001; next_d = 3; next_rdata = 8'h55;
        step();
        drain();

        // Single read from requester 2.
        set_req(2, 1'b0, 9'h010, 8'h00);
        req_valid = 4'b0100; next_d = 2; next_rdata = 8'h7E;
        step();
        drain();

        // Round robin from a fresh reset with immediate completions.
        preset = 1'b1;
        step();
        preset = 1'b0;
        for (int i = 0; i < NREQ; i++) set_req(i, i[0], ADDR_W'(9'h100 + i), DATA_W'(8'h20 + i));
        req_valid = 4'b1111; next_d = 1; next_rdata = 8'h11;
        for (int c = 0; c < 13; c++) step();
        drain();

        // Timeout on a read, then a fresh accept.
        set_req(1, 1'b0, 9'h1F0, 8'h00);
        req_valid = 4'b0010; next_d = TIMEOUT + 5; next_rdata = 8'hEE;
        step();
        drain();
        set_req(3, 1'b1, 9'h0AB, 8'h3C);
        req_valid = 4'b1000; next_d = 1;
        step();
        drain();

        // Completion on the final allowed transfer cycle.
        set_req(0, 1'b0, 9'h0FF, 8'h00);
        req_valid = 4'b0001; next_d = TIMEOUT; next_rdata = 8'hA5;
        step();
        drain();

        // Reset during the 2nd transfer cycle.
        set_req(1, 1'b1, 9'h123, 8'h99);
        req_valid = 4'b0010; next_d = 10;
        step();
        req_valid = '0;
        step();
        preset = 1'b1;
        step();
        preset = 1'b0;
        chk_reset_outputs();
        set_req(0, 1'b1, 9'h044, 8'h12);
        set_req(3, 1'b0, 9'h1C0, 8'h00);
        req_valid = 4'b1001; next_d = 2; next_rdata = 8'h5A;
        step();
        drain();
        req_valid = 4'b1000; next_d = 1; next_rdata = 8'h66;
        step();
        drain();

        // Randomized traffic; fields change every cycle to prove they are sampled only at accept.
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                a_arr[i] = ADDR_W'($urandom);
                d_arr[i] = DATA_W'($urandom);
            end
            req_write  = NREQ'($urandom);
            req_valid  = ($urandom_range(0, 3) == 0) ? '0 : NREQ'($urandom);
            next_d     = ($urandom_range(0, 4) == 0) ? $urandom_range(1, TIMEOUT + 2)
                                                     : $urandom_range(1, 4);
            next_rdata = DATA_W'($urandom);
            step();
        end
        drain();
        step();
        step();

        chk("grant_leftover", 32'(gq.size()), 32'(0));
        chk("rsp_leftover",   32'(rq.size()), 32'(0));
        chk("xfer_leftover",  32'(xq.size()), 32'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
